// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register-file write port: writeback has fixed
// priority, and a starvation counter forces a grant to the long-latency unit.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned COUNT_WIDTH = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_address,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_address,
  input  logic [31:0] mc_data,
  output logic        write_enabled,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic        starve_forced
);

  logic [COUNT_WIDTH-1:0] starve_count;
  logic                   force_grant;
  logic                   wb_fire;
  logic                   mc_fire;

  assign force_grant = (starve_count == COUNT_WIDTH'(STARVE_LIMIT));

  // Ready depends only on the competing valid and the counter, never on own valid.
  always_comb begin
    wb_ready      = 1'b0;
    mc_ready      = 1'b0;
    starve_forced = 1'b0;
    if (!reset) begin
      wb_ready      = !(force_grant && mc_valid);
      mc_ready      = !wb_valid || force_grant;
      starve_forced = force_grant && mc_valid;
    end
  end

  assign wb_fire = wb_valid && wb_ready;
  assign mc_fire = mc_valid && mc_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_count <= '0;
    end else if (mc_fire) begin
      starve_count <= '0;
    end else if (wb_valid && mc_valid) begin
      if (!force_grant) begin
        starve_count <= starve_count + 1'b1;
      end
    end else begin
      starve_count <= '0;
    end
  end

  // Address 0 is accepted but never strobed into the register file.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enabled <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else if (mc_fire) begin
      write_enabled <= |mc_address;
      write_address <= mc_address;
      write_data    <= mc_data;
    end else if (wb_fire) begin
      write_enabled <= |wb_address;
      write_address <= wb_address;
      write_data    <= wb_data;
    end else begin
      write_enabled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus predicts grants from a loss-count model and queues
// expected writes; a monitor pops them whenever the write strobe appears.
module tb_regfile_write_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        wb_valid, mc_valid;
  logic [4:0]  wb_address, mc_address;
  logic [31:0] wb_data, mc_data;
  logic        sel;

  logic        wb_ready_4, mc_ready_4, write_enabled_4, starve_forced_4;
  logic [4:0]  write_address_4;
  logic [31:0] write_data_4;
  logic        wb_ready_1, mc_ready_1, write_enabled_1, starve_forced_1;
  logic [4:0]  write_address_1;
  logic [31:0] write_data_1;

  logic        wb_ready, mc_ready, write_enabled, starve_forced;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  regfile_write_arbiter dut_4 (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready_4), .wb_address(wb_address), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready_4), .mc_address(mc_address), .mc_data(mc_data),
    .write_enabled(write_enabled_4), .write_address(write_address_4),
    .write_data(write_data_4), .starve_forced(starve_forced_4)
  );

  regfile_write_arbiter #(.STARVE_LIMIT(1)) dut_1 (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready_1), .wb_address(wb_address), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready_1), .mc_address(mc_address), .mc_data(mc_data),
    .write_enabled(write_enabled_1), .write_address(write_address_1),
    .write_data(write_data_1), .starve_forced(starve_forced_1)
  );

  assign wb_ready      = sel ? wb_ready_1      : wb_ready_4;
  assign mc_ready      = sel ? mc_ready_1      : mc_ready_4;
  assign write_enabled = sel ? write_enabled_1 : write_enabled_4;
  assign write_address = sel ? write_address_1 : write_address_4;
  assign write_data    = sel ? write_data_1    : write_data_4;
  assign starve_forced = sel ? starve_forced_1 : starve_forced_4;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          lost = 0;
  int          limit = 4;
  logic [4:0]  held_addr = '0;
  logic [31:0] held_data = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: mc wins contention only after losing 'limit' consecutive contended cycles.
  task automatic step(input logic rst,
                      input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      output logic wg, output logic mg);
    bit mc_due;
    @(negedge clock);
    reset = rst;
    wb_valid = wv; wb_address = wa; wb_data = wd;
    mc_valid = mv; mc_address = ma; mc_data = md;
    #1;
    mc_due = (lost >= limit);
    wg = 1'b0;
    mg = 1'b0;
    if (!rst) begin
      if (wv && mv) begin
        if (mc_due) mg = 1'b1;
        else        wg = 1'b1;
      end else begin
        wg = wv;
        mg = mv;
      end
    end
    check("wb_ready", wb_ready, !rst && !(mv && mc_due));
    check("mc_ready", mc_ready, !rst && (!wv || mc_due));
    check("starve_forced", starve_forced, !rst && mv && mc_due);
    check("write_address_hold", write_address, held_addr);
    check("write_data_hold", write_data, held_data);
    if (rst) begin
      held_addr = '0;
      held_data = '0;
    end else if (wg || mg) begin
      held_addr = wg ? wa : ma;
      held_data = wg ? wd : md;
      if (held_addr != 0) sb.push_back('{cyc + 1, held_addr, held_data});
    end
    if (rst || mg)     lost = 0;
    else if (wv && mv) lost = (lost < limit) ? lost + 1 : lost;
    else               lost = 0;
  endtask

  always @(posedge clock) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("write_missing", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (write_enabled === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write_enabled", write_enabled, 0);
      end else begin
        check("write_cycle", 32'(cyc), 32'(sb[0].cyc));
        check("write_address", write_address, sb[0].addr);
        check("write_data", write_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle();
    logic g0, g1;
    step(0, 0, '0, '0, 0, '0, '0, g0, g1);
  endtask

  task automatic random_run(input int n, input int pw, input int pm);
    logic        wh, mh, wg, mg, rst;
    logic [4:0]  wa, ma;
    logic [31:0] wd, md;
    wh = 0; mh = 0; wa = '0; ma = '0; wd = '0; md = '0;
    for (int i = 0; i < n; i++) begin
      if (!wh && $urandom_range(99) < pw) begin
        wh = 1; wa = 5'($urandom); wd = $urandom;
      end
      if (!mh && $urandom_range(99) < pm) begin
        mh = 1; ma = 5'($urandom); md = $urandom;
      end
      rst = ($urandom_range(63) == 0);
      step(rst, wh, wa, wd, mh, ma, md, wg, mg);
      if (wg) wh = 0;
      if (mg) mh = 0;
    end
    idle();
  endtask

  initial begin
    logic       wg, mg;
    logic [4:0] sf_seq, wbr_seq, wa;
    logic [5:0] mcr_seq;
    logic [6:0] we_seq;
    logic [4:0] ma;

    reset = 1; sel = 0;
    wb_valid = 0; wb_address = '0; wb_data = '0;
    mc_valid = 0; mc_address = '0; mc_data = '0;
    repeat (2) @(posedge clock);

    // Reset with both requesters valid.
    step(1, 1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222, wg, mg);
    step(1, 1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222, wg, mg);
    idle();
    check("reset_write_enabled", write_enabled, 0);
    check("reset_write_address", write_address, 0);
    check("reset_write_data", write_data, 0);

    // Single wb write.
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, wg, mg);
    idle();
    check("single_wb_enabled", write_enabled, 1);
    check("single_wb_address", write_address, 5'd5);
    check("single_wb_data", write_data, 32'hDEAD_BEEF);
    idle();
    check("single_wb_strobe_drop", write_enabled, 0);

    // mc write to address 0 is accepted but not strobed.
    step(0, 0, '0, '0, 1, 5'd0, 32'h1234_5678, wg, mg);
    idle();
    check("addr0_write_enabled", write_enabled, 0);

    // Starvation with limit 4: four wb grants, then a forced mc grant.
    wa = 5'd1;
    sf_seq = '0; wbr_seq = '0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, wa, {27'h0, wa}, 1, 5'd9, 32'hA5A5_A5A5, wg, mg);
      sf_seq  = {sf_seq[3:0], starve_forced};
      wbr_seq = {wbr_seq[3:0], wb_ready};
      if (wg) wa = wa + 5'd1;
    end
    idle();
    check("starve_forced_seq", sf_seq, 5'b00001);
    check("starve_wb_ready_seq", wbr_seq, 5'b11110);
    check("starve_mc_address", write_address, 5'd9);
    check("starve_mc_data", write_data, 32'hA5A5_A5A5);

    // Reset mid-stream after contention; counter must restart from zero.
    step(0, 1, 5'd7, 32'h0000_0007, 1, 5'd12, 32'h0C0C_0C0C, wg, mg);
    step(0, 1, 5'd8, 32'h0BAD_F00D, 1, 5'd12, 32'h0C0C_0C0C, wg, mg);
    step(1, 0, '0, '0, 0, '0, '0, wg, mg);
    idle();
    check("reset_drops_write", write_enabled, 0);
    step(0, 0, '0, '0, 1, 5'd12, 32'h0C0C_0C0C, wg, mg);
    check("mc_after_reset_ready", mc_ready, 1);
    wa = 5'd20;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, wa, {27'h0, wa}, 1, 5'd13, 32'h0D0D_0D0D, wg, mg);
      if (wg) wa = wa + 5'd1;
    end
    idle();

    random_run(300, 50, 50);
    random_run(300, 90, 90);

    // Switch to the limit-1 instance across a reset.
    step(1, 0, '0, '0, 0, '0, '0, wg, mg);
    sel = 1; limit = 1;
    step(1, 0, '0, '0, 0, '0, '0, wg, mg);

    // Alternation under continuous contention.
    wa = 5'd1; ma = 5'd17;
    mcr_seq = '0; we_seq = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, wa, {27'h0B00, wa}, 1, ma, {27'h0C00, ma}, wg, mg);
      mcr_seq = {mcr_seq[4:0], mc_ready};
      we_seq  = {we_seq[5:0], write_enabled};
      if (wg) wa = wa + 5'd1;
      if (mg) ma = ma + 5'd1;
    end
    idle();
    we_seq = {we_seq[5:0], write_enabled};
    check("alt_mc_ready_seq", mcr_seq, 6'b010101);
    check("alt_write_enabled_seq", we_seq, 7'b0111111);

    random_run(300, 80, 80);

    repeat (3) idle();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
